// File: rtl/sa_pkg.sv
// Shared encodings for the systolic-array cell sequencer and cell array.
package sa_pkg;

  // Cell control opcodes; codes 5-7 are reserved and never driven.
  typedef enum logic [2:0] {
    CtrlNop   = 3'd0,
    CtrlClear = 3'd1,
    CtrlLoad  = 3'd2,
    CtrlMac   = 3'd3,
    CtrlShift = 3'd4
  } ctrl_e;

  // Cell operating modes.
  localparam logic ModeAcc  = 1'b0;
  localparam logic ModeElem = 1'b1;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StCompute,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sa_phase_cnt.sv
// Loadable down-counter with zero flag; shared by the LOAD, COMPUTE and DRAIN phases.
module sa_phase_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_d, cnt_q;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sa_cell_seq.sv
// Job sequencer for a systolic cell array: CLEAR, LOAD move-buffer, COMPUTE (MAC), DRAIN (SHIFT).
module sa_cell_seq
  import sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MODE_WIDTH      = 1,
  parameter int unsigned CTRL_WIDTH      = 3,
  parameter int unsigned MOVE_BUFF_DEPTH = 16,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned DRAIN_CYCLES    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [MODE_WIDTH-1:0]              cmd_mode,
  input  logic [$clog2(MOVE_BUFF_DEPTH):0]   cmd_load_cnt,
  input  logic [LEN_WIDTH-1:0]               cmd_len,
  input  logic [DATA_WIDTH-1:0]              ld_data,
  input  logic                               ld_valid,
  output logic                               ld_ready,
  output logic [MODE_WIDTH-1:0]              mode,
  output logic [CTRL_WIDTH-1:0]              ctrl,
  output logic [DATA_WIDTH-1:0]              move_buff_in,
  output logic                               move_buff_in_valid,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  localparam int unsigned LoadCntW = $clog2(MOVE_BUFF_DEPTH) + 1;
  localparam logic [LoadCntW-1:0]  MaxLoad   = LoadCntW'(MOVE_BUFF_DEPTH);
  localparam logic [LEN_WIDTH-1:0] DrainLoad = LEN_WIDTH'(DRAIN_CYCLES - 1);

  state_e                 state_d, state_q;
  ctrl_e                  ctrl_d, ctrl_q;
  logic [MODE_WIDTH-1:0]  mode_d, mode_q;
  logic [LoadCntW-1:0]    load_cnt_d, load_cnt_q;
  logic [LEN_WIDTH-1:0]   len_d, len_q;
  logic [DATA_WIDTH-1:0]  mb_d, mb_q;
  logic                   mbv_d, mbv_q;
  logic                   ld_ready_d, ld_ready_q;
  logic                   cmd_ready_d, cmd_ready_q;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;
  logic                   err_d, err_q;

  logic                   cnt_load, cnt_dec, cnt_zero;
  logic [LEN_WIDTH-1:0]   cnt_val, cnt_cur;
  logic                   ld_fire, load_active, phase_exit;

  assign ld_fire = ld_valid && ld_ready_q;

  // Counter holds (remaining - 1) so the zero flag marks the final item of each phase.
  sa_phase_cnt #(
    .WIDTH (LEN_WIDTH)
  ) u_phase_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_cur),
    .zero_o     (cnt_zero)
  );

  // Next state plus next values of every registered output.
  always_comb begin
    state_d     = state_q;
    ctrl_d      = CtrlNop;
    mode_d      = mode_q;
    load_cnt_d  = load_cnt_q;
    len_d       = len_q;
    mb_d        = mb_q;
    mbv_d       = 1'b0;
    ld_ready_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    phase_exit  = 1'b0;
    // ld_ready is raised one cycle early (during CLEAR) so LOAD outputs follow CLEAR directly.
    load_active = (state_q == StClear) ? (load_cnt_q != '0) : ld_ready_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_load_cnt > MaxLoad) begin
            err_d = 1'b1;
          end else begin
            state_d    = StClear;
            ctrl_d     = CtrlClear;
            mode_d     = cmd_mode;
            load_cnt_d = cmd_load_cnt;
            len_d      = cmd_len;
            ld_ready_d = (cmd_load_cnt != '0);
            cnt_load   = 1'b1;
            cnt_val    = LEN_WIDTH'(cmd_load_cnt) - LEN_WIDTH'(1);
          end
        end
      end
      StClear, StLoad: begin
        if (load_active) begin
          state_d    = StLoad;
          ld_ready_d = !(ld_fire && cnt_zero);
          if (ld_fire) begin
            ctrl_d  = CtrlLoad;
            mbv_d   = 1'b1;
            mb_d    = ld_data;
            cnt_dec = 1'b1;
          end
        end else begin
          phase_exit = 1'b1;
        end
      end
      StCompute: begin
        if (cnt_zero) begin
          state_d  = StDrain;
          ctrl_d   = CtrlShift;
          cnt_load = 1'b1;
          cnt_val  = DrainLoad;
        end else begin
          ctrl_d  = CtrlMac;
          cnt_dec = 1'b1;
        end
      end
      StDrain: begin
        if (cnt_zero) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          ctrl_d  = CtrlShift;
          cnt_dec = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (phase_exit) begin
      cnt_load = 1'b1;
      if (len_q != '0) begin
        state_d = StCompute;
        ctrl_d  = CtrlMac;
        cnt_val = len_q - LEN_WIDTH'(1);
      end else begin
        state_d = StDrain;
        ctrl_d  = CtrlShift;
        cnt_val = DrainLoad;
      end
    end

    cmd_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  // State and output registers; reset wins over any concurrent command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ctrl_q      <= CtrlNop;
      mode_q      <= '0;
      load_cnt_q  <= '0;
      len_q       <= '0;
      mb_q        <= '0;
      mbv_q       <= 1'b0;
      ld_ready_q  <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      mode_q      <= mode_d;
      load_cnt_q  <= load_cnt_d;
      len_q       <= len_d;
      mb_q        <= mb_d;
      mbv_q       <= mbv_d;
      ld_ready_q  <= ld_ready_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign ld_ready           = ld_ready_q;
  assign mode               = mode_q;
  assign ctrl               = CTRL_WIDTH'(ctrl_q);
  assign move_buff_in       = mb_q;
  assign move_buff_in_valid = mbv_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;

endmodule

// File: tb/tb_sa_cell_seq.sv
// Scoreboard bench for sa_cell_seq: per-cycle expected outputs queued at drive time, checked #1 after
// the next rising edge.
module tb_sa_cell_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:0]  cmd_mode = '0;
  logic [4:0]  cmd_load_cnt = '0;
  logic [15:0] cmd_len = '0;
  logic [31:0] ld_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [0:0]  mode;
  logic [2:0]  ctrl;
  logic [31:0] move_buff_in;
  logic        move_buff_in_valid;
  logic        busy;
  logic        done;
  logic        err;

  sa_cell_seq u_dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_mode           (cmd_mode),
    .cmd_load_cnt       (cmd_load_cnt),
    .cmd_len            (cmd_len),
    .ld_data            (ld_data),
    .ld_valid           (ld_valid),
    .ld_ready           (ld_ready),
    .mode               (mode),
    .ctrl               (ctrl),
    .move_buff_in       (move_buff_in),
    .move_buff_in_valid (move_buff_in_valid),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  ctrl;
    logic        mbv;
    logic [31:0] mb;
    logic        ldr;
    logic        busy;
    logic        done;
    logic        err;
    logic        crdy;
    logic        mode;
    logic        chk_mode;
  } exp_t;

  exp_t        exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] last_mb = '0;

  localparam logic [2:0] CNop   = 3'd0;
  localparam logic [2:0] CClear = 3'd1;
  localparam logic [2:0] CLoad  = 3'd2;
  localparam logic [2:0] CMac   = 3'd3;
  localparam logic [2:0] CShift = 3'd4;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] c, input logic mbv, input logic [31:0] mb,
                          input logic ldr, input logic bsy, input logic dn, input logic er,
                          input logic crdy, input logic md, input logic chkm);
    exp_t e;
    e.ctrl = c; e.mbv = mbv; e.mb = mb; e.ldr = ldr; e.busy = bsy; e.done = dn;
    e.err = er; e.crdy = crdy; e.mode = md; e.chk_mode = chkm;
    exp_q.push_back(e);
  endtask

  // Advance one cycle and compare the DUT against the oldest queued expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("ctrl", 32'(ctrl), 32'(e.ctrl));
      check_eq("mb_valid", 32'(move_buff_in_valid), 32'(e.mbv));
      check_eq("move_buff_in", move_buff_in, e.mb);
      check_eq("ld_ready", 32'(ld_ready), 32'(e.ldr));
      check_eq("busy", 32'(busy), 32'(e.busy));
      check_eq("done", 32'(done), 32'(e.done));
      check_eq("err", 32'(err), 32'(e.err));
      check_eq("cmd_ready", 32'(cmd_ready), 32'(e.crdy));
      if (e.chk_mode) check_eq("mode", 32'(mode), 32'(e.mode));
    end
  endtask

  function automatic logic [31:0] word_of(input int k);
    case (k)
      0:       return 32'h3f80_0000;
      1:       return 32'h4000_0000;
      2:       return 32'h4040_0000;
      default: return 32'h4080_0000 + 32'(k);
    endcase
  endfunction

  // One job from the IDLE cycle; stall_n idle ld_valid cycles follow the first word.
  task automatic run_job(input logic md, input int lc, input int ln, input int stall_n,
                         input int abort_mac, input logic hold);
    int rem;
    int k;
    int stall;
    cmd_valid    = 1'b1;
    cmd_mode     = md;
    cmd_load_cnt = 5'(lc);
    cmd_len      = 16'(ln);
    push_exp(CClear, 1'b0, last_mb, lc > 0, 1'b1, 1'b0, 1'b0, 1'b0, md, 1'b1);
    step();
    if (!hold) cmd_valid = 1'b0;
    rem = lc; k = 0; stall = 0;
    while (rem > 0) begin
      if (stall > 0) begin
        ld_valid = 1'b0;
        ld_data  = $urandom;
        stall--;
        push_exp(CNop, 1'b0, last_mb, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, md, 1'b1);
      end else begin
        ld_valid = 1'b1;
        ld_data  = word_of(k);
        last_mb  = ld_data;
        rem--; k++;
        if (k == 1) stall = stall_n;
        push_exp(CLoad, 1'b1, last_mb, rem > 0, 1'b1, 1'b0, 1'b0, 1'b0, md, 1'b1);
      end
      step();
    end
    ld_valid = 1'b0;
    ld_data  = $urandom;
    for (int i = 0; i < ln; i++) begin
      push_exp(CMac, 1'b0, last_mb, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, md, 1'b1);
      step();
      if (i == abort_mac) begin
        rst       = 1'b1;
        cmd_valid = 1'b1;  // reset must beat a simultaneous command
        last_mb   = '0;
        push_exp(CNop, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        return;
      end
    end
    for (int i = 0; i < 8; i++) begin
      push_exp(CShift, 1'b0, last_mb, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, md, 1'b1);
      step();
    end
    push_exp(CNop, 1'b0, last_mb, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, md, 1'b1);
    step();
    push_exp(CNop, 1'b0, last_mb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, md, 1'b0);
    step();
  endtask

  initial begin
    // Reset state.
    push_exp(CNop, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    push_exp(CNop, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step();

    run_job(1'b0, 3, 4, 0, -1, 1'b0);   // basic job
    run_job(1'b0, 3, 4, 2, -1, 1'b0);   // two-cycle load stall
    run_job(1'b1, 0, 0, 0, -1, 1'b0);   // no load, no compute, element-wise

    // Illegal load count.
    cmd_valid    = 1'b1;
    cmd_load_cnt = 5'd17;
    cmd_len      = 16'd2;
    push_exp(CNop, 1'b0, last_mb, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    cmd_valid = 1'b0;
    push_exp(CNop, 1'b0, last_mb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    push_exp(CNop, 1'b0, last_mb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();

    run_job(1'b1, 2, 5, 0, 1, 1'b0);    // reset in 2nd MAC cycle
    run_job(1'b0, 1, 2, 0, -1, 1'b0);   // accepted right after reset
    run_job(1'b1, 16, 3, 1, -1, 1'b1);  // max depth, cmd_valid held through the job
    run_job(1'b0, 0, 2, 0, -1, 1'b0);   // accepted in the IDLE cycle after done

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
